// File: rtl/branch_issue_queue.sv
// branch_issue_queue: in-order branch/jump/AUIPC issue queue; tracks source readiness from
// writeback wakeups and releases only the head, once both its sources are ready.
module branch_issue_queue #(
  parameter int DEPTH = 8,
  parameter int PAYLOAD_W = 128
) (
  input  logic                   cpu_clock_i,
  input  logic                   cpu_reset_i,
  input  logic                   flush_i,
  input  logic                   disp_valid_i,
  output logic                   disp_ready_o,
  input  logic [PAYLOAD_W-1:0]   disp_payload_i,
  input  logic [5:0]             disp_rs1_i,
  input  logic [5:0]             disp_rs2_i,
  input  logic                   disp_rs1_rdy_i,
  input  logic                   disp_rs2_rdy_i,
  input  logic [5:0]             disp_rob_i,
  input  logic [2:0]             wake_valid_i,
  input  logic [17:0]            wake_tag_i,
  input  logic                   iss_stall_i,
  output logic                   iss_valid_o,
  output logic [PAYLOAD_W-1:0]   iss_payload_o,
  output logic [5:0]             iss_rs1_o,
  output logic [5:0]             iss_rs2_o,
  output logic [5:0]             iss_rob_o,
  output logic [$clog2(DEPTH):0] occupancy_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] head, tail;
  logic [AW-1:0] h, t;
  logic [PAYLOAD_W-1:0] pay_q [DEPTH];
  logic [5:0] rs1_q [DEPTH];
  logic [5:0] rs2_q [DEPTH];
  logic [5:0] rob_q [DEPTH];
  logic [DEPTH-1:0] rdy1_q, rdy2_q, vld_q;
  logic push, pop;
  // Tag 0 is the hardwired zero register and never waits on a writeback.
  function automatic logic woken(input logic [5:0] tag, input logic [2:0] wv, input logic [17:0] wt);
    woken = tag == 6'd0;
    for (int k = 0; k < 3; k++) woken = woken | (wv[k] && wt[6*k +: 6] == tag);
  endfunction
  assign h = head[AW-1:0];
  assign t = tail[AW-1:0];
  assign occupancy_o = tail - head;
  assign empty_o = occupancy_o == '0;
  assign disp_ready_o = occupancy_o < (AW+1)'(DEPTH);
  assign push = disp_valid_i && disp_ready_o && !flush_i;
  assign pop = vld_q[h] && !iss_stall_i && !flush_i
    && (rdy1_q[h] || woken(rs1_q[h], wake_valid_i, wake_tag_i))
    && (rdy2_q[h] || woken(rs2_q[h], wake_valid_i, wake_tag_i));
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      head <= '0;
      tail <= '0;
      vld_q <= '0;
      iss_valid_o <= 1'b0;
      iss_payload_o <= '0;
      iss_rs1_o <= '0;
      iss_rs2_o <= '0;
      iss_rob_o <= '0;
    end else if (flush_i) begin
      head <= '0;
      tail <= '0;
      vld_q <= '0;
      iss_valid_o <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (woken(rs1_q[i], wake_valid_i, wake_tag_i)) rdy1_q[i] <= 1'b1;
        if (woken(rs2_q[i], wake_valid_i, wake_tag_i)) rdy2_q[i] <= 1'b1;
      end
      iss_valid_o <= pop;
      if (pop) begin
        vld_q[h] <= 1'b0;
        head <= head + 1'b1;
        iss_payload_o <= pay_q[h];
        iss_rs1_o <= rs1_q[h];
        iss_rs2_o <= rs2_q[h];
        iss_rob_o <= rob_q[h];
      end
      if (push) begin
        pay_q[t] <= disp_payload_i;
        rs1_q[t] <= disp_rs1_i;
        rs2_q[t] <= disp_rs2_i;
        rob_q[t] <= disp_rob_i;
        rdy1_q[t] <= disp_rs1_rdy_i || woken(disp_rs1_i, wake_valid_i, wake_tag_i);
        rdy2_q[t] <= disp_rs2_rdy_i || woken(disp_rs2_i, wake_valid_i, wake_tag_i);
        vld_q[t] <= 1'b1;
        tail <= tail + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_branch_issue_queue.sv
// tb_branch_issue_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_branch_issue_queue;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst, flush, disp_valid, disp_ready, rs1_rdy, rs2_rdy, stall;
  logic [127:0] disp_pay, iss_pay;
  logic [5:0] rs1, rs2, rob, iss_rs1, iss_rs2, iss_rob;
  logic [2:0] wake_valid;
  logic [17:0] wake_tag;
  logic iss_valid, empty;
  logic [3:0] occ;
  int checks = 0, errors = 0;
  bit chk_en = 0;

  typedef struct {
    logic [127:0] pay;
    logic [5:0] rs1, rs2, rob;
    bit r1, r2;
  } ent_t;
  ent_t q[$];
  bit ev;
  logic [127:0] ep;
  logic [5:0] e1, e2, erob;

  branch_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(128)) dut (
    .cpu_clock_i(clk), .cpu_reset_i(rst), .flush_i(flush),
    .disp_valid_i(disp_valid), .disp_ready_o(disp_ready), .disp_payload_i(disp_pay),
    .disp_rs1_i(rs1), .disp_rs2_i(rs2), .disp_rs1_rdy_i(rs1_rdy), .disp_rs2_rdy_i(rs2_rdy),
    .disp_rob_i(rob), .wake_valid_i(wake_valid), .wake_tag_i(wake_tag), .iss_stall_i(stall),
    .iss_valid_o(iss_valid), .iss_payload_o(iss_pay), .iss_rs1_o(iss_rs1), .iss_rs2_o(iss_rs2),
    .iss_rob_o(iss_rob), .occupancy_o(occ), .empty_o(empty));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit woke(input logic [5:0] tag);
    woke = tag == 6'd0;
    for (int k = 0; k < 3; k++) if (wake_valid[k] && wake_tag[6*k +: 6] == tag) woke = 1;
  endfunction

  // Reference: the queue is a plain list in program order; compute the next edge's effect.
  task automatic model_step();
    ent_t e;
    bit iss, psh;
    if (rst) begin
      q.delete();
      ev = 0; ep = '0; e1 = '0; e2 = '0; erob = '0;
    end else if (flush) begin
      q.delete();
      ev = 0;
    end else begin
      iss = q.size() > 0 && (q[0].r1 || woke(q[0].rs1)) && (q[0].r2 || woke(q[0].rs2)) && !stall;
      psh = disp_valid && q.size() < DEPTH;
      foreach (q[i]) begin
        q[i].r1 = q[i].r1 | woke(q[i].rs1);
        q[i].r2 = q[i].r2 | woke(q[i].rs2);
      end
      ev = iss;
      if (iss) begin
        e = q.pop_front();
        ep = e.pay; e1 = e.rs1; e2 = e.rs2; erob = e.rob;
      end
      if (psh) begin
        e.pay = disp_pay; e.rs1 = rs1; e.rs2 = rs2; e.rob = rob;
        e.r1 = rs1_rdy || woke(rs1);
        e.r2 = rs2_rdy || woke(rs2);
        q.push_back(e);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("iss_valid", iss_valid, ev);
      chk("iss_payload", iss_pay, ep);
      chk("iss_rs1", iss_rs1, e1);
      chk("iss_rs2", iss_rs2, e2);
      chk("iss_rob", iss_rob, erob);
      chk("occupancy", occ, q.size());
      chk("empty", empty, q.size() == 0);
      chk("disp_ready", disp_ready, q.size() < DEPTH);
    end
  end

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic clr();
    rst = 0; flush = 0; disp_valid = 0; disp_pay = '0; rs1 = 0; rs2 = 0;
    rs1_rdy = 0; rs2_rdy = 0; rob = 0; wake_valid = 0; wake_tag = 0; stall = 0;
  endtask

  task automatic disp(input logic [5:0] a, input bit ar, input logic [5:0] b, input bit br, input logic [5:0] r);
    disp_valid = 1; rs1 = a; rs1_rdy = ar; rs2 = b; rs2_rdy = br; rob = r;
    disp_pay = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    int n;
    clr();
    rst = 1;
    tick();
    chk_en = 1;
    tick();
    clr();
    chk("rst_valid", iss_valid, 0);
    chk("rst_occ", occ, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", disp_ready, 1);
    // single ready op: issues two cycles after dispatch
    disp(6'd5, 1, 6'd0, 0, 6'd3);
    tick();
    clr();
    chk("t1_occ", occ, 1);
    tick();
    chk("t1_valid", iss_valid, 1);
    chk("t1_rob", iss_rob, 3);
    chk("t1_empty", empty, 1);
    tick();
    chk("t1_done", iss_valid, 0);
    // non-ready head blocks a ready younger op until woken
    disp(6'd9, 0, 6'd0, 0, 6'd1);
    tick();
    disp(6'd0, 1, 6'd0, 1, 6'd2);
    tick();
    clr();
    tick();
    tick();
    chk("t2_blocked", iss_valid, 0);
    chk("t2_occ", occ, 2);
    wake_valid = 3'b010;
    wake_tag = {6'd0, 6'd9, 6'd0};
    tick();
    clr();
    chk("t2_a_valid", iss_valid, 1);
    chk("t2_a_rob", iss_rob, 1);
    tick();
    chk("t2_b_valid", iss_valid, 1);
    chk("t2_b_rob", iss_rob, 2);
    tick();
    // fill to full with waiting ops, then wake all
    for (int i = 0; i < DEPTH; i++) begin
      disp(6'(10 + i), 0, 6'd0, 1, 6'(i));
      tick();
    end
    clr();
    chk("t3_full_occ", occ, 8);
    chk("t3_full_ready", disp_ready, 0);
    disp(6'd0, 1, 6'd0, 1, 6'd60);
    tick();
    clr();
    chk("t3_ignored", occ, 8);
    n = 0;
    wake_valid = 3'b111; wake_tag = {6'd12, 6'd11, 6'd10};
    tick(); n += int'(iss_valid);
    wake_tag = {6'd15, 6'd14, 6'd13};
    tick(); n += int'(iss_valid);
    wake_valid = 3'b011; wake_tag = {6'd0, 6'd17, 6'd16};
    tick(); n += int'(iss_valid);
    clr();
    for (int i = 0; i < 8; i++) begin
      tick();
      n += int'(iss_valid);
    end
    chk("t3_issues", n, 8);
    chk("t3_ready", disp_ready, 1);
    // same-cycle wakeup at dispatch
    disp(6'd0, 0, 6'd12, 0, 6'd7);
    wake_valid = 3'b100; wake_tag = {6'd12, 6'd0, 6'd0};
    tick();
    clr();
    tick();
    chk("t4_valid", iss_valid, 1);
    chk("t4_rob", iss_rob, 7);
    tick();
    // stall holds ready ops
    for (int i = 0; i < 4; i++) begin
      disp(6'd0, 1, 6'd0, 1, 6'(20 + i));
      stall = 1;
      tick();
    end
    clr();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stalled", iss_valid, 0);
    end
    chk("t5_occ", occ, 4);
    stall = 0;
    tick();
    chk("t5_first", iss_rob, 20);
    tick();
    chk("t5_second", iss_rob, 21);
    tick(); tick(); tick();
    // flush with concurrent dispatch
    for (int i = 0; i < 5; i++) begin
      disp(6'd0, 1, 6'd0, 1, 6'(30 + i));
      stall = 1;
      tick();
    end
    disp(6'd0, 1, 6'd0, 1, 6'd40);
    flush = 1;
    tick();
    clr();
    chk("t6_occ", occ, 0);
    chk("t6_empty", empty, 1);
    chk("t6_valid", iss_valid, 0);
    tick();
    chk("t6_absent", iss_valid, 0);
    // random traffic
    for (int c = 0; c < 4000; c++) begin
      clr();
      rst = $urandom_range(0, 199) == 0;
      flush = $urandom_range(0, 49) == 0;
      stall = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 1) == 1)
        disp(6'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
             6'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, 6'($urandom));
      wake_valid = 3'($urandom);
      wake_tag = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
      tick();
    end
    clr();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_issue_queue.md
# branch_issue_queue

In-order issue queue that sequences branch/jump/AUIPC micro-ops into the single branch unit. Holds dispatched ops with physical source tags, tracks operand readiness from writeback wakeups, and releases the oldest op to the branch unit only once both its sources are ready, so branches resolve strictly in program order. Sits between rename/dispatch and the branch unit's register-read stage.

## Interface
- DEPTH, 8, queue entries; power of two, >= 2
- PAYLOAD_W, 128, opaque per-op payload (offset, pc, op flags, bnch_cond, dest, BTB info); never interpreted
- cpu_clock_i  in  1  clock
- cpu_reset_i  in  1  reset; synchronous, active-high
- flush_i  in  1  pipeline flush; discards all queued ops
- disp_valid_i  in  1  dispatch request
- disp_ready_o  out  1  queue can accept this cycle
- disp_payload_i  in  PAYLOAD_W  op payload
- disp_rs1_i, disp_rs2_i  in  6 each  physical source tags
- disp_rs1_rdy_i, disp_rs2_rdy_i  in  1 each  source already valid at dispatch
- disp_rob_i  in  6  ROB id
- wake_valid_i  in  3  writeback wakeup valids (one per writeback port)
- wake_tag_i  in  18  three 6-bit destination tags, port k at [6k+5:6k]
- iss_stall_i  in  1  inhibit issue this cycle
- iss_valid_o  out  1  issued op valid
- iss_payload_o  out  PAYLOAD_W  issued payload
- iss_rs1_o, iss_rs2_o  out  6 each  issued source tags
- iss_rob_o  out  6  issued ROB id
- occupancy_o  out  $clog2(DEPTH)+1  entries held
- empty_o  out  1  occupancy_o == 0

## Operation
- Circular buffer: head/tail pointers with one extra wrap bit; occupancy = tail - head.
- Per entry: payload, rs1, rs2, rob, rdy1, rdy2, valid.
- Push when disp_valid_i && disp_ready_o && !flush_i && !cpu_reset_i. disp_ready_o = occupancy < DEPTH (registered state only; no credit for a same-cycle pop).
- Ready at push: rdyN = disp_rsN_rdy_i | (disp_rsN_i == 0) | any k: wake_valid_i[k] && wake_tag_i[k] == disp_rsN_i.
- Wakeup: every valid entry, every port k: wake_valid_i[k] && tag match sets rdyN. Tag 0 never waits. Ready bits never clear except on pop/flush/reset.
- Issue decision (combinational on head): head valid, both sources ready counting same-cycle wakeups (bypass), !iss_stall_i, !flush_i. If so, pop head, register issue outputs.
- Only the head may issue; a ready younger op waits behind a non-ready head.
- Flush: head = tail = 0, all valid bits cleared, iss_valid_o = 0 next cycle; push and issue in the flush cycle are discarded.
- Push and pop same cycle allowed; occupancy unchanged.

## Timing
- Reset values: iss_valid_o 0, iss_payload_o/iss_rs1_o/iss_rs2_o/iss_rob_o 0, occupancy_o 0, empty_o 1, disp_ready_o 1.
- iss_valid_o is registered, one-cycle pulse per op; no backpressure from the branch unit.
- Dispatch with ready sources at cycle t into empty queue: head at t+1, iss_valid_o at t+2.
- Wakeup of head's last source at cycle t: iss_valid_o at t+1 (bypass).
- Back-to-back ready ops: one issue per cycle, iss_valid_o continuously high.
- iss_stall_i at cycle t: no pop at t, iss_valid_o 0 at t+1; queue contents held.
- flush_i with iss_valid_o high in the same cycle: that issued op is already out; downstream flush kills it.
- Reset mid-operation: same effect as flush plus all outputs to reset values next cycle.
- Pointer wrap: mod DEPTH via wrap bit; full when pointers equal with differing wrap bits.

## Test plan
- Reset, then dispatch 1 op, rs1=5 rdy, rs2=0, rob=3 at cycle 1 -> iss_valid_o=1, iss_rob_o=3 at cycle 3; empty_o=1 after.
- Dispatch op A (rs1=9 not ready) then op B (all ready) -> nothing issues; wake_tag port 1 = 9 at cycle 6 -> A issues at 7, B at 8, in order.
- Fill with 8 ops, none ready -> disp_ready_o=0, occupancy_o=8; further disp_valid_i ignored; wake all tags -> 8 consecutive issues, pointers wrap, disp_ready_o=1 once occupancy < 8.
- Dispatch op with rs2=12 not ready while wake port 2 = 12 same cycle -> rdy2 captured; issues 2 cycles later.
- 4 ready ops queued, iss_stall_i high 3 cycles -> no issue during stall; resumes in order next cycle.
- 5 ops queued, flush_i with concurrent dispatch -> next cycle occupancy_o=0, empty_o=1, iss_valid_o=0, dispatched op absent.
